// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// Latency/backpressure: n/a (declarations only).
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ctrl_state_t;

    localparam int DEF_MEM_TIMEOUT = 15;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register an EX load is producing.
// Latency: purely combinational. Backpressure: none.
module pipe_hazard_detect (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       em2reg,
    input  logic [4:0] edest,
    output logic       lu
);

    // $zero is never a real dependency
    assign lu = em2reg && (edest != 5'd0) &&
                ((id_use_rs && (id_rs == edest)) || (id_use_rt && (id_rt == edest)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/clears, branch redirect, load-use stall, dmem handshake.
// Latency: all controls combinational from state and inputs; freeze held while a dmem access is outstanding.
// Optional PIPE_HAZARD_CTRL_PERF_EN adds stall_cycles/flush_count counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        em2reg,
    input  logic [4:0]  edest,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic        mbeq,
    input  logic        mbne,
    input  logic        mz,
    input  logic [31:0] mbpc,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        exmem_clr,
    output logic        memwb_clr,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        mem_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t     state, state_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic            run;
    logic            err_set;
    logic            mem_op, take, lu;
    logic            freeze, flush, lu_stall;

    pipe_hazard_detect u_detect (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .em2reg    (em2reg),
        .edest     (edest),
        .lu        (lu)
    );

    assign mem_op = mm2reg | mwmem;
    assign take   = (mbeq & mz) | (mbne & ~mz);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            run     <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            run   <= 1'b1;
            if (err_set)
                mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_set   = 1'b0;
        dmem_req  = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        if (run) begin
            case (state)
                IDLE: begin
                    dmem_req = mem_op;
                    // an access not acked on issue already holds MEM in place
                    if (mem_op && !dmem_ack) begin
                        freeze    = 1'b1;
                        state_nxt = WAIT;
                        cnt_nxt   = '0;
                    end else if (take) begin
                        flush = 1'b1;
                    end
                end
                WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        state_nxt = IDLE;
                    end else if (cnt == TO_LAST) begin
                        state_nxt = IDLE;
                        err_set   = 1'b1;
                    end else begin
                        freeze  = 1'b1;
                        cnt_nxt = cnt + TO_W'(1);
                    end
                end
            endcase
        end
        lu_stall = run & lu & ~freeze & ~flush;
    end

    assign pc_we       = ~(freeze | lu_stall);
    assign ifid_we     = ~(freeze | lu_stall);
    assign idex_we     = ~freeze;
    assign exmem_we    = ~freeze;
    assign ifid_clr    = flush;
    assign idex_clr    = flush | lu_stall;
    assign exmem_clr   = flush;
    assign memwb_clr   = freeze;
    assign pc_redirect = flush;
    assign redirect_pc = mbpc;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (freeze | lu_stall)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl against a transaction-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MT     = 4;
    localparam int CYCLES = 3000;

    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  id_rs, id_rt, edest;
    logic        id_use_rs, id_use_rt, em2reg;
    logic        mm2reg, mwmem, mbeq, mbne, mz, dmem_ack;
    logic [31:0] mbpc;
    logic        dmem_req, pc_we, ifid_we, idex_we, exmem_we;
    logic        ifid_clr, idex_clr, exmem_clr, memwb_clr, pc_redirect, mem_err;
    logic [31:0] redirect_pc;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .TO_W(8)) dut (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .em2reg(em2reg), .edest(edest), .mm2reg(mm2reg), .mwmem(mwmem),
        .mbeq(mbeq), .mbne(mbne), .mz(mz), .mbpc(mbpc), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .exmem_clr(exmem_clr), .memwb_clr(memwb_clr), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  ctrl;
        logic [31:0] rpc;
        logic        err;
        logic [31:0] stalls;
        logic [31:0] flushes;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: an outstanding access with a patience budget in cycles.
    bit          m_run, m_pending, m_err;
    int          m_patience;
    logic [31:0] m_stalls, m_flushes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pending = 0; m_err = 0; m_patience = 0;
        m_stalls = '0; m_flushes = '0;
    endtask

    initial begin
        bit   rst, access, taken, hazard, hold, flush, lus, finished, gave_up;
        exp_t e;
        clrn = 1'b0;
        {id_rs, id_rt, edest} = '0;
        {id_use_rs, id_use_rt, em2reg, mm2reg, mwmem, mbeq, mbne, mz, dmem_ack} = '0;
        mbpc = '0;
        model_reset();
        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            #1;
            rst  = (c < 2) || ($urandom_range(0, 99) == 0);
            clrn = !rst;
            id_rs     = 5'($urandom_range(0, 3));
            id_rt     = 5'($urandom_range(0, 3));
            edest     = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1));
            id_use_rt = 1'($urandom_range(0, 1));
            em2reg    = 1'($urandom_range(0, 1));
            mm2reg    = ($urandom_range(0, 9) < 2);
            mwmem     = ($urandom_range(0, 9) < 2);
            mbeq      = ($urandom_range(0, 3) == 0);
            mbne      = ($urandom_range(0, 3) == 0);
            mz        = 1'($urandom_range(0, 1));
            mbpc      = $urandom;
            dmem_ack  = ($urandom_range(0, 9) < 3);
            if (rst)
                model_reset();

            access = mm2reg || mwmem;
            taken  = (mbeq && mz) || (mbne && !mz);
            hazard = em2reg && edest != 0 &&
                     ((id_use_rs && id_rs == edest) || (id_use_rt && id_rt == edest));
            finished = 0; gave_up = 0;
            if (!m_run) begin
                hold = 0; flush = 0;
            end else if (m_pending) begin
                finished = dmem_ack;
                gave_up  = !dmem_ack && m_patience == 1;
                hold     = !finished && !gave_up;
                flush    = 0;
            end else begin
                hold  = access && !dmem_ack;
                flush = !hold && taken;
            end
            lus = m_run && hazard && !hold && !flush;

            e.ctrl = {m_run && (m_pending || access), !(hold || lus), !(hold || lus),
                      !hold, !hold, flush, flush || lus, flush, hold, flush};
            e.rpc     = mbpc;
            e.err     = m_err;
            e.stalls  = m_stalls;
            e.flushes = m_flushes;
            exp_q.push_back(e);

            if (!rst) begin
                if (m_run) begin
                    if (m_pending) begin
                        if (finished) m_pending = 0;
                        else if (gave_up) begin m_pending = 0; m_err = 1; end
                        else m_patience--;
                    end else if (access && !dmem_ack) begin
                        m_pending  = 1;
                        m_patience = MT;
                    end
                    if (hold || lus) m_stalls++;
                    if (flush) m_flushes++;
                end
                m_run = 1;
            end
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ctrl{req,pcwe,ifidwe,idexwe,exmemwe,ifidclr,idexclr,exmemclr,memwbclr,redir}",
                32'({dmem_req, pc_we, ifid_we, idex_we, exmem_we, ifid_clr, idex_clr,
                     exmem_clr, memwb_clr, pc_redirect}), 32'(e.ctrl));
            chk("redirect_pc", redirect_pc, e.rpc);
            chk("mem_err", 32'(mem_err), 32'(e.err));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            chk("stall_cycles", stall_cycles, e.stalls);
            chk("flush_count", flush_count, e.flushes);
`endif
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central sequencing controller for the 5-stage MIPS pipeline. It drives the write-enable and clear controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, resolves branches held in the EX/MEM register (taken branch flushes the younger stages), and runs a request/acknowledge handshake with a variable-latency data memory, freezing the pipeline while an access is outstanding.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max WAIT cycles before an access is abandoned (1..255)
- TO_W, 8: width of the wait counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- clrn  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- em2reg  in  1  EX instruction is a load
- edest  in  5  EX destination register
- mm2reg, mwmem  in  1 each  MEM instruction is load / store
- mbeq, mbne, mz  in  1 each  MEM branch type and ALU zero flag
- mbpc  in  32  MEM branch target
- dmem_ack  in  1  data memory completes the current access
- dmem_req  out  1  data memory access request
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  stage register enables
- ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  synchronous bubble insert
- pc_redirect  out  1  load next PC from redirect_pc
- redirect_pc  out  32  equals mbpc
- mem_err  out  1  sticky access-timeout flag

## Operation
- run flag: cleared by reset, set on the first clk edge after clrn deasserts. While run=0, dmem_req=0, pc_redirect=0, all enables 1, all clears 0.
- FSM states: IDLE, WAIT.
- IDLE: mem_op = mm2reg|mwmem. dmem_req = run & mem_op.
  - If mem_op is set and dmem_ack=1 in the same cycle, the access completes with zero stall.
  - If mem_op is set and dmem_ack=0, go to WAIT and load the counter with 0.
- WAIT: dmem_req=1. pc_we=ifid_we=idex_we=exmem_we=0 and memwb_clr=1, which freezes the pipeline and bubbles WB.
  - On dmem_ack=1: release the freeze in this cycle and go to IDLE.
  - If the counter reaches MEM_TIMEOUT-1 without ack: set mem_err, release, go to IDLE.
  - Otherwise the counter increments.
- Branch: take = mbeq&mz | mbne&~mz. When run & take (IDLE only): pc_redirect=1, redirect_pc=mbpc, and ifid_clr=idex_clr=exmem_clr=1.
- Load-use: lu = em2reg & edest!=0 & (id_use_rs&id_rs==edest | id_use_rt&id_rt==edest). When asserted: pc_we=ifid_we=0 and idex_clr=1 for one cycle.
- Priority is memory freeze > branch flush > load-use. Under freeze, all clears except memwb_clr are 0. A taken branch suppresses the load-use stall, because the load is being flushed.
- mem_err is cleared only by reset.

## Timing
- All control outputs are combinational from state and current inputs. There is no added latency.
- Reset values: state=IDLE, counter=0, mem_err=0, run=0. Outputs take the run=0 values above.
- Single-cycle memory (ack with req) costs 0 stall cycles. An ack N cycles after req costs N freeze cycles.
- Timeout abandons the access after exactly MEM_TIMEOUT WAIT cycles.
- Reset mid-WAIT: returns immediately to IDLE and drops dmem_req asynchronously.
- If dmem_ack and timeout fall in the same cycle, ack wins and mem_err is not set.
- dmem_ack while in IDLE with no mem_op is ignored.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: adds outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0 and wrapping at 2^32.
  - stall_cycles increments once per cycle in which the freeze or load-use stall is active.
  - flush_count increments once per taken branch.
- Undefined: these ports and counters do not exist, and the behaviour is otherwise identical.

## Structure
- Shared package pipe_ctrl_pkg holds the FSM state enum (IDLE, WAIT) and the default MEM_TIMEOUT constant.
- One sub-module, pipe_hazard_detect, is the purely combinational load-use comparator producing lu. The FSM, counter and priority logic live in the top module.

## Test plan
- Load-use: em2reg=1, edest=8, id_rs=8, id_use_rs=1 -> one cycle with pc_we=ifid_we=0 and idex_clr=1. With edest=0 -> no stall.
- Taken beq: mbeq=1, mz=1, mbpc=0x0040_0020 -> pc_redirect=1, redirect_pc=0x0040_0020, ifid/idex/exmem_clr=1. With mz=0 -> no redirect.
- Zero-wait load: mm2reg=1 with dmem_ack=1 in the same cycle -> dmem_req=1, no freeze, FSM stays in IDLE.
- 3-cycle memory: mwmem=1, ack 3 cycles later -> exactly 3 freeze cycles with memwb_clr=1, then IDLE. A concurrent load-use sees idex_clr=0 during the freeze.
- Timeout: mm2reg=1, no ack, MEM_TIMEOUT=4 -> release after 4 WAIT cycles and mem_err=1 sticky. Ack in the 4th cycle -> mem_err stays 0.
- Reset in WAIT: clrn pulsed low -> dmem_req=0 immediately, state IDLE, mem_err=0. With PIPE_HAZARD_CTRL_PERF_EN defined, stall_cycles=0.
